// File: rtl/matmul_sequencer_if.sv
// Purpose : bundles the dual-port memory_map connection and job status of matmul_sequencer.
// Ports   : master = sequencer side (drives addresses/write data/enables/busy/done, reads q);
//           slave  = memory side (returns registered read data one cycle after the address).
interface matmul_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic        [ADDR_WIDTH-1:0] mem_addr_a;
    logic        [ADDR_WIDTH-1:0] mem_addr_b;
    logic        [DATA_WIDTH-1:0] mem_data_a;
    logic                         mem_we_a;
    logic                         mem_we_b;
    logic signed [DATA_WIDTH-1:0] mem_q_a;
    logic signed [DATA_WIDTH-1:0] mem_q_b;
    logic                         busy;
    logic                         done;

    modport master (
        output mem_addr_a, mem_addr_b, mem_data_a, mem_we_a, mem_we_b, busy, done,
        input  mem_q_a, mem_q_b
    );

    modport slave (
        input  mem_addr_a, mem_addr_b, mem_data_a, mem_we_a, mem_we_b, busy, done,
        output mem_q_a, mem_q_b
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Purpose : polls MATMUL_Flag, reads M/N/P, computes C = A*B element by element through
//           memory_map ports A/B, writes C row-major, then clears the flag.
// Ports   : clk, rst_n (synchronous, active-low), bus (matmul_sequencer_if.master).
// Latency : per C element N+2 cycles (N MAC issues, 1 drain, 1 write); job = 6 + M*P*(N+2).
// Option  : define MATMUL_SEQ_SAT_EN to saturate written C values to the signed DATA_WIDTH range;
//           otherwise the low DATA_WIDTH bits of the accumulator are written (wrapping).
module matmul_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int POLL_INTERVAL = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matmul_sequencer_if.master    bus
);

    localparam int ACC_WIDTH = 2 * DATA_WIDTH;
    localparam int PCW       = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    localparam logic [PCW-1:0]        POLL_LAST = PCW'(POLL_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] REG_A     = ADDR_WIDTH'(12'h000);
    localparam logic [ADDR_WIDTH-1:0] REG_B     = ADDR_WIDTH'(12'h100);
    localparam logic [ADDR_WIDTH-1:0] REG_C     = ADDR_WIDTH'(12'h200);
    localparam logic [ADDR_WIDTH-1:0] REG_M     = ADDR_WIDTH'(12'h600);
    localparam logic [ADDR_WIDTH-1:0] REG_N     = ADDR_WIDTH'(12'h700);
    localparam logic [ADDR_WIDTH-1:0] REG_P     = ADDR_WIDTH'(12'h800);
    localparam logic [ADDR_WIDTH-1:0] REG_FLAG  = ADDR_WIDTH'(12'hA00);
    localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ONE_D     = DATA_WIDTH'(1);

`ifdef MATMUL_SEQ_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_POLL, S_CFG0, S_CFG1, S_CFG2, S_CHECK, S_MAC, S_DRAIN, S_WRITE, S_CLEAR
    } state_t;

    state_t state, state_nxt;

    logic [PCW-1:0]               poll_cnt;
    logic                         poll_pend;   // flag read data arrives this cycle
    logic                         cfg_tail;    // second CFG2 cycle: capture N/P, no new reads
    logic [DATA_WIDTH-1:0]        dim_m, dim_n, dim_p;
    logic [DATA_WIDTH-1:0]        i_idx, j_idx, k_idx;
    logic [ADDR_WIDTH-1:0]        ptr_a, ptr_b, ptr_c, row_a, col_b;
    logic                         mac_vld;     // a product is on mem_q_a/mem_q_b this cycle
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  prod;
    logic [DATA_WIDTH-1:0]        wr_val;
    logic [ADDR_WIDTH-1:0]        n_a, p_a;
    logic                         last_k, last_j, last_elem, dim_zero;

    logic [ADDR_WIDTH-1:0]        addr_a, addr_b;
    logic [DATA_WIDTH-1:0]        data_a;
    logic                         we_a, busy, done;

    assign prod = $signed({{DATA_WIDTH{bus.mem_q_a[DATA_WIDTH-1]}}, bus.mem_q_a})
                * $signed({{DATA_WIDTH{bus.mem_q_b[DATA_WIDTH-1]}}, bus.mem_q_b});

    assign n_a       = ADDR_WIDTH'(dim_n);
    assign p_a       = ADDR_WIDTH'(dim_p);
    assign last_k    = (k_idx == dim_n - ONE_D);
    assign last_j    = (j_idx == dim_p - ONE_D);
    assign last_elem = last_j && (i_idx == dim_m - ONE_D);
    assign dim_zero  = (dim_m == '0) || (dim_n == '0) || (dim_p == '0);

    always_comb begin
`ifdef MATMUL_SEQ_SAT_EN
        if (acc > SAT_MAX) begin
            wr_val = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc < SAT_MIN) begin
            wr_val = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            wr_val = acc[DATA_WIDTH-1:0];
        end
`else
        wr_val = acc[DATA_WIDTH-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (poll_pend && (bus.mem_q_b != '0)) begin
                    state_nxt = S_CFG0;
                end else if (poll_cnt == POLL_LAST) begin
                    state_nxt = S_POLL;
                end
            end
            S_POLL:  state_nxt = S_IDLE;
            S_CFG0:  state_nxt = S_CFG1;
            S_CFG1:  state_nxt = S_CFG2;
            S_CFG2:  if (cfg_tail) state_nxt = S_CHECK;
            S_CHECK: state_nxt = dim_zero ? S_CLEAR : S_MAC;
            S_MAC:   if (last_k) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_elem ? S_CLEAR : S_MAC;
            S_CLEAR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        addr_a = '0;
        addr_b = '0;
        data_a = '0;
        we_a   = 1'b0;
        done   = 1'b0;
        busy   = (state != S_IDLE) && (state != S_POLL);
        case (state)
            S_POLL: addr_b = REG_FLAG;
            // Matrix bases sit at fixed addresses; the base reads keep the fixed
            // 4-cycle configuration window but their data is not needed.
            S_CFG0: begin
                addr_a = REG_A;
                addr_b = REG_B;
            end
            S_CFG1: begin
                addr_a = REG_C;
                addr_b = REG_M;
            end
            S_CFG2: begin
                if (!cfg_tail) begin
                    addr_a = REG_N;
                    addr_b = REG_P;
                end
            end
            S_MAC: begin
                addr_a = ptr_a;
                addr_b = ptr_b;
            end
            S_WRITE: begin
                addr_a = ptr_c;
                data_a = wr_val;
                we_a   = 1'b1;
            end
            S_CLEAR: begin
                addr_a = REG_FLAG;
                we_a   = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr_a = addr_a;
    assign bus.mem_addr_b = addr_b;
    assign bus.mem_data_a = data_a;
    assign bus.mem_we_a   = we_a;
    assign bus.mem_we_b   = 1'b0;
    assign bus.busy       = busy;
    assign bus.done       = done;

    // Datapath: poll timer, configuration capture, pointers and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
            cfg_tail  <= 1'b0;
            dim_m     <= '0;
            dim_n     <= '0;
            dim_p     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            ptr_a     <= '0;
            ptr_b     <= '0;
            ptr_c     <= '0;
            row_a     <= '0;
            col_b     <= '0;
            mac_vld   <= 1'b0;
            acc       <= '0;
        end else begin
            mac_vld <= (state == S_MAC);
            if (mac_vld) begin
                acc <= acc + prod;
            end
            case (state)
                S_IDLE: begin
                    poll_pend <= 1'b0;
                    if ((poll_pend && (bus.mem_q_b != '0)) || (poll_cnt == POLL_LAST)) begin
                        poll_cnt <= '0;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                S_POLL: begin
                    poll_pend <= 1'b1;
                    poll_cnt  <= '0;
                end
                S_CFG0: cfg_tail <= 1'b0;
                S_CFG2: begin
                    if (!cfg_tail) begin
                        cfg_tail <= 1'b1;
                        dim_m    <= bus.mem_q_b;
                    end else begin
                        dim_n    <= bus.mem_q_a;
                        dim_p    <= bus.mem_q_b;
                    end
                end
                S_CHECK: begin
                    i_idx <= '0;
                    j_idx <= '0;
                    k_idx <= '0;
                    ptr_a <= REG_A;
                    row_a <= REG_A;
                    ptr_b <= REG_B;
                    col_b <= REG_B;
                    ptr_c <= REG_C;
                    acc   <= '0;
                end
                S_MAC: begin
                    k_idx <= k_idx + ONE_D;
                    ptr_a <= ptr_a + ONE_A;
                    ptr_b <= ptr_b + p_a;
                end
                S_WRITE: begin
                    acc   <= '0;
                    k_idx <= '0;
                    ptr_c <= ptr_c + ONE_A;
                    if (last_j) begin
                        // next row of C: advance A row base by N, restart B at column 0
                        j_idx <= '0;
                        i_idx <= i_idx + ONE_D;
                        row_a <= row_a + n_a;
                        ptr_a <= row_a + n_a;
                        col_b <= REG_B;
                        ptr_b <= REG_B;
                    end else begin
                        j_idx <= j_idx + ONE_D;
                        ptr_a <= row_a;
                        col_b <= col_b + ONE_A;
                        ptr_b <= col_b + ONE_A;
                    end
                end
                S_CLEAR: begin
                    poll_cnt  <= '0;
                    poll_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Purpose : self-checking bench for matmul_sequencer with a behavioural memory_map and a
//           loop-level matrix-product reference model.
// Ports   : none (top-level bench); drives clk/rst_n and the slave side of the interface.
module tb_matmul_sequencer;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matmul_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POLL_INTERVAL(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // memory_map model: registered read on both ports, write on port A
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        bus.mem_q_a <= mem[bus.mem_addr_a[11:0]];
        bus.mem_q_b <= mem[bus.mem_addr_b[11:0]];
        if (bus.mem_we_a) mem[bus.mem_addr_a[11:0]] <= bus.mem_data_a;
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observation log, sampled on the falling edge
    int          cyc = 0;
    int          busy_cnt, done_cnt, busy_rise, web_bad, idle_bad;
    logic        busy_d = 1'b0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          poll_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) busy_cnt++;
            if (bus.busy && !busy_d) busy_rise = cyc;
            if (bus.done) done_cnt++;
            if (bus.mem_we_b) web_bad++;
            if (bus.mem_we_a) begin
                wr_addr.push_back(bus.mem_addr_a);
                wr_data.push_back(bus.mem_data_a);
                wr_cyc.push_back(cyc);
            end
            if (!bus.busy && bus.mem_addr_b == 32'hA00) poll_cyc.push_back(cyc);
            if (!bus.busy && (bus.mem_we_a || bus.mem_addr_a != 0 || bus.mem_data_a != 0 ||
                              (bus.mem_addr_b != 0 && bus.mem_addr_b != 32'hA00)))
                idle_bad++;
        end
        busy_d = rst_n ? bus.busy : 1'b0;
    end

    task automatic clear_log();
        busy_cnt = 0; done_cnt = 0; busy_rise = -1; web_bad = 0; idle_bad = 0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); poll_cyc.delete();
    endtask

    // Reference model
    int          a_mat [0:15];
    int          b_mat [0:15];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    function automatic logic [31:0] c_value(input longint acc);
`ifdef MATMUL_SEQ_SAT_EN
        if (acc > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (acc < -64'sd2147483648) return 32'h8000_0000;
        else                             return acc[31:0];
`else
        return acc[31:0];
`endif
    endfunction

    task automatic load_job(input int m, input int n, input int p);
        exp_addr.delete(); exp_data.delete();
        for (int x = 0; x < 256; x++) mem[12'h200 + x] = 32'hDEAD_BEEF;
        for (int x = 0; x < m * n; x++) mem[x] = a_mat[x];
        for (int x = 0; x < n * p; x++) mem[12'h100 + x] = b_mat[x];
        mem[12'h600] = m; mem[12'h700] = n; mem[12'h800] = p;
        if (m != 0 && n != 0 && p != 0) begin
            for (int i = 0; i < m; i++)
                for (int j = 0; j < p; j++) begin
                    longint acc = 0;
                    for (int k = 0; k < n; k++)
                        acc += longint'(a_mat[i * n + k]) * longint'(b_mat[k * p + j]);
                    exp_addr.push_back(32'h200 + i * p + j);
                    exp_data.push_back(c_value(acc));
                end
        end
        exp_addr.push_back(32'hA00);
        exp_data.push_back(32'h0);
        mem[12'hA00] = 32'h1;
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!bus.busy && n < budget) begin @(posedge clk); #1; n++; end
        chk("busy_timeout", bus.busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin @(posedge clk); #1; n++; end
        chk("done_timeout", done_cnt > 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_job(input string name, input int m, input int n, input int p);
        int nw;
        chk({name, ".n_writes"}, wr_addr.size(), exp_addr.size());
        nw = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
        for (int x = 0; x < nw; x++) begin
            chk($sformatf("%s.wr_addr%0d", name, x), wr_addr[x], exp_addr[x]);
            chk($sformatf("%s.wr_data%0d", name, x), wr_data[x], exp_data[x]);
        end
        if (m * n * p != 0 && nw == m * p + 1) begin
            chk({name, ".first_lat"}, wr_cyc[0] - busy_rise, n + 6);
            for (int x = 1; x < m * p; x++)
                chk($sformatf("%s.gap%0d", name, x), wr_cyc[x] - wr_cyc[x - 1], n + 2);
            chk({name, ".clear_gap"}, wr_cyc[m * p] - wr_cyc[m * p - 1], 1);
        end
        chk({name, ".busy_cycles"}, busy_cnt, (m * n * p == 0) ? 6 : 6 + m * p * (n + 2));
        chk({name, ".done_pulses"}, done_cnt, 1);
        chk({name, ".flag"}, mem[12'hA00], 0);
        chk({name, ".we_b"}, web_bad, 0);
    endtask

    task automatic run_job(input string name, input int m, input int n, input int p);
        load_job(m, n, p);
        clear_log();
        wait_done(3000);
        check_job(name, m, n, p);
    endtask

    function automatic int rand_val();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 200)) - 100;
        else                           return int'($urandom());
    endfunction

    task automatic set_2x2();
        a_mat[0] = 1; a_mat[1] = 2; a_mat[2] = 3; a_mat[3] = 4;
        b_mat[0] = 5; b_mat[1] = 6; b_mat[2] = 7; b_mat[3] = 8;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        int c_ref [0:3];
        int m, n, p;
        c_ref[0] = 19; c_ref[1] = 22; c_ref[2] = 43; c_ref[3] = 50;
        for (int x = 0; x < 4096; x++) mem[x] = 32'h0;
        clear_log();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy",   bus.busy,       0);
        chk("rst.done",   bus.done,       0);
        chk("rst.we_a",   bus.mem_we_a,   0);
        chk("rst.we_b",   bus.mem_we_b,   0);
        chk("rst.addr_a", bus.mem_addr_a, 0);
        chk("rst.addr_b", bus.mem_addr_b, 0);
        chk("rst.data_a", bus.mem_data_a, 0);

        // Idle polling with the flag clear
        rst_n = 1'b1;
        clear_log();
        repeat (100) @(posedge clk);
        #1;
        chk("idle.poll_count_ge5", poll_cyc.size() >= 5, 1);
        for (int x = 1; x < poll_cyc.size(); x++)
            chk($sformatf("idle.poll_gap%0d", x), poll_cyc[x] - poll_cyc[x - 1], 17);
        chk("idle.writes", wr_addr.size(), 0);
        chk("idle.busy",   busy_cnt,       0);
        chk("idle.outputs", idle_bad,      0);

        // 2x2x2 reference product
        set_2x2();
        run_job("j222", 2, 2, 2);
        for (int x = 0; x < 4; x++)
            if (x < wr_data.size()) chk($sformatf("j222.c%0d", x), wr_data[x], c_ref[x]);

        // Zero dimension: no C writes, only the flag clear
        set_2x2();
        run_job("n0", 2, 0, 2);

        // Overflow at the DATA_WIDTH boundary
        a_mat[0] = 32'h7FFF_FFFF; b_mat[0] = 2;
        run_job("ovf_pos", 1, 1, 1);
`ifdef MATMUL_SEQ_SAT_EN
        chk("ovf_pos.c", wr_data[0], 32'h7FFF_FFFF);
`else
        chk("ovf_pos.c", wr_data[0], 32'hFFFF_FFFE);
`endif
        a_mat[0] = 32'h8000_0000; b_mat[0] = 2;
        run_job("ovf_neg", 1, 1, 1);
`ifdef MATMUL_SEQ_SAT_EN
        chk("ovf_neg.c", wr_data[0], 32'h8000_0000);
`else
        chk("ovf_neg.c", wr_data[0], 32'h0000_0000);
`endif

        // Random jobs; host scribbles the dimension registers mid-job
        for (int t = 0; t < 6; t++) begin
            m = $urandom_range(1, 3); n = $urandom_range(1, 4); p = $urandom_range(1, 3);
            for (int x = 0; x < 16; x++) begin a_mat[x] = rand_val(); b_mat[x] = rand_val(); end
            load_job(m, n, p);
            clear_log();
            wait_busy(100);
            repeat (6) @(posedge clk);
            #1;
            mem[12'h600] = 7; mem[12'h700] = 9; mem[12'h800] = 5;
            wait_done(3000);
            check_job($sformatf("rnd%0d", t), m, n, p);
        end

        // Reset during MAC abandons the job; the flag survives and the job reruns
        set_2x2();
        load_job(2, 2, 2);
        clear_log();
        wait_busy(100);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst.busy",   bus.busy,       0);
        chk("mrst.we_a",   bus.mem_we_a,   0);
        chk("mrst.addr_a", bus.mem_addr_a, 0);
        chk("mrst.addr_b", bus.mem_addr_b, 0);
        chk("mrst.flag",   mem[12'hA00],   1);
        chk("mrst.no_wr",  wr_addr.size(), 0);
        rst_n = 1'b1;
        clear_log();
        wait_done(3000);
        check_job("mrst_rerun", 2, 2, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the element and register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the memory-map address width.
REQ-003 SHALL have parameter POLL_INTERVAL, default 16, the number of cycles between MATMUL_Flag polls.
REQ-004 SHALL have clk, input, 1: the single clock, with all logic on its rising edge.
REQ-005 SHALL have rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have mem_addr_a / mem_addr_b, output, ADDR_WIDTH: the port A/B address to memory_map.
REQ-007 SHALL have mem_data_a, output, DATA_WIDTH: the port A write data; port B never writes.
REQ-008 SHALL have mem_we_a / mem_we_b, output, 1: the port write enables; mem_we_b is tied to 0.
REQ-009 SHALL have mem_q_a / mem_q_b, input, DATA_WIDTH signed: read data, valid exactly 1 cycle after the address is issued.
REQ-010 SHALL have busy, output, 1: high from job accept until the flag-clear write completes.
REQ-011 SHALL have done, output, 1: a one-cycle pulse in the cycle the flag-clear write is issued.

Function
REQ-012 SHALL use fixed register addresses: A base 0x000, B base 0x100, C base 0x200, Dim_M 0x600, Dim_N 0x700, Dim_P 0x800, MATMUL_Flag 0xA00.
REQ-013 SHALL implement states IDLE, POLL, CFG0, CFG1, CFG2, CHECK, MAC, DRAIN, WRITE, CLEAR.
REQ-014 IDLE SHALL count POLL_INTERVAL cycles, then enter POLL and issue a port-B read of 0xA00; a nonzero mem_q_b the next cycle goes to CFG0, zero returns to IDLE.
REQ-015 CFG0/CFG1/CFG2 SHALL each issue one read per port: (A base, B base), (C base, Dim_M), (Dim_N, Dim_P), capturing data one cycle later; 4 cycles total.
REQ-016 CHECK SHALL go to CLEAR without any C write if Dim_M, Dim_N or Dim_P is 0, else to MAC with i=j=k=0 and acc=0.
REQ-017 MAC SHALL issue one pair per cycle, port A at A+i*N+k and port B at B+k*P+j, for k=0..N-1, using incrementing pointers and no address multipliers.
REQ-018 The accumulator SHALL be signed 2*DATA_WIDTH and add the full-width product of mem_q_a*mem_q_b one cycle after each issue.
REQ-019 DRAIN (1 cycle) SHALL absorb the last product; WRITE SHALL issue mem_we_a=1 at C+i*P+j.
REQ-020 Each C element SHALL take exactly N+2 cycles from first MAC issue to its write, in row-major order (j fastest).
REQ-021 After WRITE, acc SHALL clear; the next element starts MAC the following cycle, and after (M-1,P-1) the block enters CLEAR.
REQ-022 CLEAR SHALL write 0 to 0xA00 on port A, pulse done, deassert busy, and return to IDLE with the poll counter reset.
REQ-023 All address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; dimensions are unsigned.
REQ-024 Outside WRITE and CLEAR, mem_we_a SHALL be 0; in IDLE, addresses and data SHALL be 0.
REQ-025 Port writes by the host during a job SHALL be ignored; configuration is latched only in CFG0-CFG2.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL enter IDLE with the poll counter, pointers, counters and acc at 0, and all outputs at 0.
REQ-027 Reset mid-job SHALL abandon the job without clearing the flag; the job restarts on the next poll after reset.

Configuration
REQ-028 With MATMUL_SEQ_SAT_EN defined, the WRITE value SHALL be acc saturated to the signed DATA_WIDTH range.
REQ-029 Without MATMUL_SEQ_SAT_EN, the WRITE value SHALL be acc[DATA_WIDTH-1:0], wrapping.

Verification
REQ-030 M=N=P=2, A=[1,2;3,4], B=[5,6;7,8] -> C=[19,22;43,50] written in order; each element takes 4 cycles; flag cleared; done pulses once.
REQ-031 Flag=1 with Dim_N=0 -> no C writes; 0xA00 written 0; done pulses; busy lasts CFG+CHECK+CLEAR (6 cycles).
REQ-032 M=N=P=1, A=0x7FFFFFFF, B=2 -> C=0x7FFFFFFF with MATMUL_SEQ_SAT_EN, 0xFFFFFFFE without; A=0x80000000, B=2 -> 0x80000000 saturated.
REQ-033 Flag held 0 for 100 cycles -> a port-B read of 0xA00 every 17 cycles (16 IDLE + 1 POLL), no writes, busy=0.
REQ-034 rst_n=0 for 1 cycle during MAC of a 2x2x2 job -> outputs 0, flag stays 1; the job reruns in full and produces the REQ-030 result.
